// File: rtl/fetch_r32i.sv
// fetch_r32i -- RV32I instruction fetch stage.
//
// Issues in-order instruction memory requests for the PC's FetchAddr, keeps
// the address of every in-flight request in a small pending queue, and
// buffers returned words with their addresses in a DEPTH-entry FIFO that
// feeds decode over a valid/ready handshake. A Redirect (taken branch)
// clears the FIFO and drops responses still in flight for the old path.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   When defined, a misaligned FetchAddr (bits [1:0] != 0) is never sent to
//   memory; a NOP fault entry with InstrFault=1 is queued instead.
//
// Ports:
//   clock, nReset                 clock, synchronous active-low reset
//   FetchAddr / AddrAccept        PC address in, "address taken" back to PC
//   Redirect                      taken branch, FetchAddr holds the target
//   IMemReq/IMemAddr/IMemGnt      memory request channel
//   IMemRValid/IMemRData          in-order memory response channel
//   InstrValid/InstrReady         decode handshake
//   Instr/InstrAddr(/InstrFault)  FIFO head contents
module fetch_r32i #(
  parameter int dataW   = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic             clock,
  input  logic             nReset,
  input  logic [dataW-1:0] FetchAddr,
  output logic             AddrAccept,
  input  logic             Redirect,
  output logic             IMemReq,
  output logic [dataW-1:0] IMemAddr,
  input  logic             IMemGnt,
  input  logic             IMemRValid,
  input  logic [31:0]      IMemRData,
  output logic             InstrValid,
  input  logic             InstrReady,
  output logic [31:0]      Instr,
  output logic [dataW-1:0] InstrAddr
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic             InstrFault
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int PD = 2 ** PW;
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  state_t           state;
  logic [OW-1:0]    outstanding;
  logic [OW-1:0]    discard;

  logic [31:0]      fifo_data [DEPTH];
  logic [dataW-1:0] fifo_addr [DEPTH];
`ifdef FETCH_ALIGN_CHECK_EN
  logic             fifo_flt  [DEPTH];
`endif
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    fifo_count;

  logic [dataW-1:0] pend_addr [PD];
  logic [PW-1:0]    pend_rd;
  logic [PW-1:0]    pend_wr;

  logic             misaligned;
  logic [CW:0]      occupancy;
  logic             room;
  logic             in_run;
  logic             req;
  logic             grant;
  logic             flt_push;
  logic             rsp;
  logic             rsp_push;
  logic             push;
  logic             pop;
  logic [OW-1:0]    out_next;
  logic [OW-1:0]    disc_next;
  logic [31:0]      push_data;
  logic [dataW-1:0] push_addr;

  // Request/response/handshake decode for the current cycle.
  always_comb begin
    misaligned = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    misaligned = (FetchAddr[1:0] != 2'b00);
`endif
    // Buffered words plus in-flight requests: a request is only issued when
    // every response is guaranteed a FIFO slot.
    occupancy = {1'b0, fifo_count} + (CW+1)'(outstanding);
    room      = occupancy < (CW+1)'(DEPTH);
    in_run    = (state == RUN) && !Redirect;
    req       = in_run && !misaligned && (outstanding < OW'(MAX_OUT)) && room;
    grant     = req && IMemGnt;
    flt_push  = in_run && misaligned && (outstanding == OW'(0)) && room;
    // With nothing outstanding a response is a protocol error: ignored.
    rsp       = IMemRValid && (outstanding != OW'(0));
    rsp_push  = rsp && in_run;
    push      = rsp_push || flt_push;
    pop       = (fifo_count != CW'(0)) && InstrReady && !Redirect;
    out_next  = outstanding + OW'(grant) - OW'(rsp);
    if (Redirect) begin
      disc_next = out_next;
    end else if (rsp && (discard != OW'(0))) begin
      disc_next = discard - OW'(1);
    end else begin
      disc_next = discard;
    end
    if (flt_push) begin
      push_data = NOP;
      push_addr = FetchAddr;
    end else begin
      push_data = IMemRData;
      push_addr = pend_addr[pend_rd];
    end
  end

  assign IMemReq    = req;
  assign IMemAddr   = req ? FetchAddr : {dataW{1'b0}};
  assign AddrAccept = grant || flt_push;
  assign InstrValid = (fifo_count != CW'(0));
  assign Instr      = InstrValid ? fifo_data[rd_ptr] : 32'h0000_0000;
  assign InstrAddr  = InstrValid ? fifo_addr[rd_ptr] : {dataW{1'b0}};
`ifdef FETCH_ALIGN_CHECK_EN
  assign InstrFault = InstrValid ? fifo_flt[rd_ptr] : 1'b0;
`endif

  // Storage arrays; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_addr[wr_ptr] <= push_addr;
`ifdef FETCH_ALIGN_CHECK_EN
      fifo_flt[wr_ptr]  <= flt_push;
`endif
    end
    if (grant) begin
      pend_addr[pend_wr] <= FetchAddr;
    end
  end

  // Control state: FSM, counters and pointers.
  always_ff @(posedge clock) begin
    if (!nReset) begin
      state       <= IDLE;
      outstanding <= OW'(0);
      discard     <= OW'(0);
      rd_ptr      <= AW'(0);
      wr_ptr      <= AW'(0);
      fifo_count  <= CW'(0);
      pend_rd     <= PW'(0);
      pend_wr     <= PW'(0);
    end else begin
      outstanding <= out_next;
      if (grant) begin
        pend_wr <= pend_wr + PW'(1);
      end
      // Responses retire pending addresses in every state, including FLUSH.
      if (rsp) begin
        pend_rd <= pend_rd + PW'(1);
      end
      if (Redirect) begin
        rd_ptr     <= AW'(0);
        wr_ptr     <= AW'(0);
        fifo_count <= CW'(0);
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
      case (state)
        IDLE: begin
          state   <= RUN;
          discard <= OW'(0);
        end
        RUN: begin
          if (Redirect && (out_next != OW'(0))) begin
            state   <= FLUSH;
            discard <= out_next;
          end else begin
            state   <= RUN;
            discard <= OW'(0);
          end
        end
        FLUSH: begin
          discard <= disc_next;
          state   <= (disc_next == OW'(0)) ? RUN : FLUSH;
        end
        default: begin
          state   <= IDLE;
          discard <= OW'(0);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_r32i.sv
// Scoreboard bench for fetch_r32i: the PC driver pushes the expected
// {address, word} for every accepted address; a monitor pops and compares on
// every decode handshake. A memory model answers grants in order after a
// programmable latency.
module tb_fetch_r32i;
  logic        clock = 1'b0;
  logic        nReset;
  logic [31:0] FetchAddr;
  logic        AddrAccept;
  logic        Redirect;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemGnt;
  logic        IMemRValid;
  logic [31:0] IMemRData;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instr;
  logic [31:0] InstrAddr;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        InstrFault;
`endif

  always #5 clock = ~clock;

  fetch_r32i #(.dataW(32), .DEPTH(4), .MAX_OUT(2)) dut (
    .clock(clock), .nReset(nReset), .FetchAddr(FetchAddr), .AddrAccept(AddrAccept),
    .Redirect(Redirect), .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemGnt(IMemGnt),
    .IMemRValid(IMemRValid), .IMemRData(IMemRData), .InstrValid(InstrValid),
    .InstrReady(InstrReady), .Instr(Instr), .InstrAddr(InstrAddr)
`ifdef FETCH_ALIGN_CHECK_EN
    , .InstrFault(InstrFault)
`endif
  );

  typedef struct packed { logic [31:0] addr; logic [31:0] instr; logic flt; } exp_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] due; } mreq_t;

  exp_t        expq[$];
  mreq_t       memq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = 32'd0;
  logic [31:0] mem_lat = 32'd1;
  logic [31:0] pc;
  logic [31:0] redir_tgt = 32'd0;
  logic        redir_pending = 1'b0;
  int          n;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  // Memory model: records grants, answers in order once the latency elapses.
  initial begin
    IMemRValid = 1'b0;
    IMemRData  = 32'd0;
    forever begin
      @(negedge clock);
      if (IMemReq && IMemGnt) memq.push_back('{addr: IMemAddr, due: cyc + mem_lat});
      @(posedge clock); #1;
      cyc = cyc + 32'd1;
      if (memq.size() != 0 && memq[0].due <= cyc) begin
        IMemRValid = 1'b1;
        IMemRData  = mem_word(memq[0].addr);
        void'(memq.pop_front());
      end else begin
        IMemRValid = 1'b0;
        IMemRData  = 32'd0;
      end
    end
  end

  // Monitor: compares every instruction handed to decode with the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (nReset && InstrValid && InstrReady) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr actual addr=%08h word=%08h required=none", InstrAddr, Instr);
        end else begin
          e = expq.pop_front();
          check("instr_addr", InstrAddr, e.addr);
          check("instr_word", Instr, e.instr);
`ifdef FETCH_ALIGN_CHECK_EN
          check("instr_fault", 32'(InstrFault), 32'(e.flt));
`endif
          if (redir_pending) begin
            check("first_after_redirect", InstrAddr, redir_tgt);
            redir_pending = 1'b0;
          end
        end
      end
    end
  end

  // PC model: advances on AddrAccept and records the expected entry.
  task automatic run(input int cycles, output int accepted);
    exp_t e;
    accepted = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (AddrAccept) begin
        e = '{addr: FetchAddr, instr: mem_word(FetchAddr), flt: 1'b0};
`ifdef FETCH_ALIGN_CHECK_EN
        if (FetchAddr[1:0] != 2'b00) e = '{addr: FetchAddr, instr: 32'h0000_0013, flt: 1'b1};
`endif
        expq.push_back(e);
        pc = pc + 32'd4;
        accepted++;
      end
      @(posedge clock); #1;
      FetchAddr = pc;
    end
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    IMemGnt = 1'b0;
    Redirect = 1'b0;
    expq.delete();
    redir_pending = 1'b0;
    @(posedge clock); #1;
    nReset = 1'b1;
    #1;
    check("rst_imemreq", 32'(IMemReq), 32'd0);
    check("rst_accept", 32'(AddrAccept), 32'd0);
    check("rst_valid", 32'(InstrValid), 32'd0);
    check("rst_instr", Instr, 32'd0);
    check("rst_instr_addr", InstrAddr, 32'd0);
    check("rst_imemaddr", IMemAddr, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    check("rst_fault", 32'(InstrFault), 32'd0);
`endif
  endtask

  task automatic redirect(input logic [31:0] tgt);
    logic saved;
    saved = InstrReady;
    InstrReady = 1'b0;
    Redirect = 1'b1;
    FetchAddr = tgt;
    pc = tgt;
    expq.delete();
    redir_tgt = tgt;
    redir_pending = 1'b1;
    @(negedge clock);
    check("redir_no_req", 32'(IMemReq), 32'd0);
    check("redir_no_accept", 32'(AddrAccept), 32'd0);
    @(posedge clock); #1;
    Redirect = 1'b0;
    InstrReady = saved;
    #1;
    check("redir_valid_cleared", 32'(InstrValid), 32'd0);
  endtask

  task automatic drain();
    int dummy;
    IMemGnt = 1'b0;
    InstrReady = 1'b1;
    for (int i = 0; i < 40 && expq.size() != 0; i++) run(1, dummy);
    check("drain_empty", 32'(expq.size()), 32'd0);
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nReset = 1'b0; FetchAddr = 32'd0; Redirect = 1'b0; IMemGnt = 1'b0; InstrReady = 1'b0;
    pc = 32'd0;
    do_reset();

    // 1: streaming fetch 0,4,8,... with 1-cycle memory.
    IMemGnt = 1'b1; InstrReady = 1'b1; mem_lat = 32'd1;
    run(1, n);
    check("t1_first_cycle_no_accept", 32'(n), 32'd0);
    run(6, n);
    check("t1_accept_every_cycle", 32'(n), 32'd6);
    drain();

    // 2: decode stalled -> exactly DEPTH words buffered, then released in order.
    IMemGnt = 1'b1; InstrReady = 1'b0; mem_lat = 32'd1;
    run(10, n);
    #1;
    check("t2_buffered", 32'(expq.size()), 32'd4);
    check("t2_req_blocked", 32'(IMemReq), 32'd0);
    check("t2_valid", 32'(InstrValid), 32'd1);
    check("t2_head_addr", InstrAddr, expq[0].addr);
    InstrReady = 1'b1;
    run(6, n);
    check("t2_fetch_resumed", 32'(n != 0), 32'd1);
    drain();

    // 3: two requests in flight, redirect to 0x100, stale words dropped.
    IMemGnt = 1'b1; InstrReady = 1'b1; mem_lat = 32'd6;
    run(3, n);
    redirect(32'h0000_0100);
    check("t3_flush_no_req", 32'(IMemReq), 32'd0);
    run(15, n);
    drain();

    // 4: redirect in a cycle carrying a response and a would-be grant.
    IMemGnt = 1'b1; InstrReady = 1'b1; mem_lat = 32'd1;
    run(5, n);
    redirect(32'h0000_0180);
    run(8, n);
    drain();

    // 5: reset with two requests outstanding; late responses ignored.
    IMemGnt = 1'b1; InstrReady = 1'b1; mem_lat = 32'd3;
    run(2, n);
    do_reset();
    run(6, n);
    check("t5_late_rsp_ignored", 32'(InstrValid), 32'd0);
    pc = 32'h0000_0200; FetchAddr = pc; IMemGnt = 1'b1; mem_lat = 32'd1;
    run(8, n);
    drain();

`ifdef FETCH_ALIGN_CHECK_EN
    // 6: misaligned target produces fault entries instead of requests.
    IMemGnt = 1'b1; InstrReady = 1'b0; mem_lat = 32'd1;
    redirect(32'h0000_0102);
    run(8, n);
    #1;
    check("t6_no_req", 32'(IMemReq), 32'd0);
    check("t6_fault", 32'(InstrFault), 32'd1);
    check("t6_nop", Instr, 32'h0000_0013);
    check("t6_addr", InstrAddr, 32'h0000_0102);
    check("t6_buffered", 32'(expq.size()), 32'd4);
    InstrReady = 1'b1;
    run(3, n);
    redirect(32'h0000_0300);
    run(6, n);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
